// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared bus/pc defines and fetch FSM state type
//   ADDR_BUS / DATA_BUS / MEM_SEL_BUS : bus ranges
//   INIT_PC                           : default first fetch address
//   ST_*                              : 2-bit fetch FSM encodings
`ifndef INST_FETCH_DEFS
`define INST_FETCH_DEFS
`define ADDR_BUS 31:0
`define DATA_BUS 31:0
`define MEM_SEL_BUS 3:0
`define INIT_PC 32'hBFC0_0000
`define ST_RESET 2'b00
`define ST_FETCH 2'b01
`define ST_FAULT 2'b10
`endif

package inst_fetch_pkg;
   typedef enum logic [1:0] {
      S_RESET = `ST_RESET,
      S_FETCH = `ST_FETCH,
      S_FAULT = `ST_FAULT
   } state_t;
   localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC mux
//   flush/flush_pc         : exception redirect (highest priority)
//   branch_flag/branch_addr: branch resolved this cycle
//   pending_valid/addr     : branch captured earlier, not yet consumed
//   pc                     : current PC, incremented by 4 otherwise
//   next_pc                : selected next PC
import inst_fetch_pkg::*;

module pc_next_sel (
   input  logic           flush,
   input  logic [`ADDR_BUS] flush_pc,
   input  logic           branch_flag,
   input  logic [`ADDR_BUS] branch_addr,
   input  logic           pending_valid,
   input  logic [`ADDR_BUS] pending_addr,
   input  logic [`ADDR_BUS] pc,
   output logic [`ADDR_BUS] next_pc
);
   // The +4 wraps naturally modulo 2^32.
   always_comb
      next_pc = flush ? flush_pc :
                branch_flag ? branch_addr :
                pending_valid ? pending_addr : pc + PC_STEP;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC owner, ROM read initiator and IF/ID register
//   clk, rst                  : clock, sync active-high reset
//   stall, flush, flush_pc    : pipeline stall and exception redirect
//   branch_flag, branch_addr  : taken branch from decode (delay slot kept)
//   rom_*                     : instruction ROM port (combinational read)
//   id_valid/id_ready         : IF/ID handshake
//   id_pc, id_inst, id_adel   : fetched entry and address-error flag
import inst_fetch_pkg::*;

module inst_fetch #(
   parameter logic [31:0] RESET_PC = `INIT_PC
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               flush,
   input  logic [`ADDR_BUS]   flush_pc,
   input  logic               branch_flag,
   input  logic [`ADDR_BUS]   branch_addr,
   output logic               rom_en,
   output logic [`MEM_SEL_BUS] rom_write_en,
   output logic [`ADDR_BUS]   rom_addr,
   output logic [`DATA_BUS]   rom_write_data,
   input  logic [`DATA_BUS]   rom_read_data,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [`ADDR_BUS]   id_pc,
   output logic [`DATA_BUS]   id_inst,
   output logic               id_adel
);
   state_t state;
   logic [`ADDR_BUS] pc, pending_addr, next_pc;
   logic pending_valid, advance, misaligned;

   assign misaligned = pc[1:0] != 2'b00;
   assign advance = state == S_FETCH && !stall && (!id_valid || id_ready);
   assign rom_en = advance && !misaligned;
   assign rom_addr = pc;
   assign rom_write_en = '0;
   assign rom_write_data = '0;

   // Branch input is gated by advance so a branch seen while not advancing
   // only lands in pending and never moves the PC early.
   pc_next_sel u_sel (
      .flush(flush),
      .flush_pc(flush_pc),
      .branch_flag(branch_flag && advance),
      .branch_addr(branch_addr),
      .pending_valid(pending_valid),
      .pending_addr(pending_addr),
      .pc(pc),
      .next_pc(next_pc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_RESET;
         pc <= RESET_PC;
         pending_valid <= 1'b0;
         pending_addr <= '0;
         id_valid <= 1'b0;
         id_pc <= '0;
         id_inst <= '0;
         id_adel <= 1'b0;
      end else if (flush) begin
         state <= S_FETCH;
         pc <= next_pc;
         pending_valid <= 1'b0;
         id_valid <= 1'b0;
      end else if (advance) begin
         pc <= next_pc;
         pending_valid <= 1'b0;
         id_valid <= 1'b1;
         id_pc <= pc;
         id_inst <= misaligned ? '0 : rom_read_data;
         id_adel <= misaligned;
         if (misaligned) state <= S_FAULT;
      end else begin
         if (branch_flag) begin
            pending_valid <= 1'b1;
            pending_addr <= branch_addr;
         end
         if (!stall) begin
            if (state == S_RESET) state <= S_FETCH;
            // Outside FETCH nothing refills IF/ID, so a consumed entry drains.
            if (state != S_FETCH && id_ready) id_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed self-checking bench for inst_fetch
module tb_inst_fetch;
   localparam logic [31:0] RP = 32'h0000_0040;
   localparam logic [31:0] K = 32'hA5A5_0000;

   logic clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0, branch_flag = 1'b0, id_ready = 1'b1;
   logic [31:0] flush_pc = '0, branch_addr = '0, rom_addr, rom_write_data, rom_read_data, id_pc, id_inst;
   logic [3:0] rom_write_en;
   logic rom_en, id_valid, id_adel;
   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   // ROM model: word content is a fixed function of its address.
   assign rom_read_data = rom_addr ^ K;

   inst_fetch #(.RESET_PC(RP)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
      .branch_flag(branch_flag), .branch_addr(branch_addr),
      .rom_en(rom_en), .rom_write_en(rom_write_en), .rom_addr(rom_addr),
      .rom_write_data(rom_write_data), .rom_read_data(rom_read_data),
      .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
      .id_inst(id_inst), .id_adel(id_adel)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick();
      tick();
      chk("rst_rom_addr", rom_addr, RP);
      chk("rst_rom_en", {31'd0, rom_en}, 32'd0);
      chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
      chk("rst_id_pc", id_pc, 32'd0);
      chk("rst_id_inst", id_inst, 32'd0);
      chk("rst_id_adel", {31'd0, id_adel}, 32'd0);
      chk("rst_we", {28'd0, rom_write_en}, 32'd0);
      chk("rst_wdata", rom_write_data, 32'd0);
      rst = 1'b0;
      #1;
      chk("reset_cycle_rom_en", {31'd0, rom_en}, 32'd0);
      tick();
      chk("first_rom_en", {31'd0, rom_en}, 32'd1);
      chk("first_addr", rom_addr, RP);
      chk("first_id_valid", {31'd0, id_valid}, 32'd0);
      tick();
      chk("seq1_valid", {31'd0, id_valid}, 32'd1);
      chk("seq1_id_pc", id_pc, RP);
      chk("seq1_id_inst", id_inst, RP ^ K);
      chk("seq1_addr", rom_addr, RP + 32'd4);
      tick();
      chk("seq2_id_pc", id_pc, RP + 32'd4);
      chk("seq2_addr", rom_addr, RP + 32'd8);
      // branch resolved while +8 (delay slot) is being fetched
      branch_flag = 1'b1;
      branch_addr = 32'h0000_0100;
      tick();
      branch_flag = 1'b0;
      chk("dslot_id_pc", id_pc, RP + 32'd8);
      chk("br_addr", rom_addr, 32'h100);
      tick();
      chk("br_id_pc", id_pc, 32'h100);
      chk("br_id_inst", id_inst, 32'h100 ^ K);
      tick();
      chk("br_next_id_pc", id_pc, 32'h104);
      chk("br_next_addr", rom_addr, 32'h108);
      // back-pressure for 3 cycles, branch in the second
      id_ready = 1'b0;
      #1;
      chk("bp_rom_en", {31'd0, rom_en}, 32'd0);
      tick();
      chk("bp_hold_pc", id_pc, 32'h104);
      branch_flag = 1'b1;
      branch_addr = 32'h0000_0200;
      #1;
      chk("bp_br_rom_en", {31'd0, rom_en}, 32'd0);
      tick();
      branch_flag = 1'b0;
      chk("bp_hold_addr", rom_addr, 32'h108);
      tick();
      chk("bp_hold_inst", id_inst, 32'h104 ^ K);
      chk("bp_hold_valid", {31'd0, id_valid}, 32'd1);
      id_ready = 1'b1;
      #1;
      chk("rel_rom_en", {31'd0, rom_en}, 32'd1);
      chk("rel_dslot_addr", rom_addr, 32'h108);
      tick();
      chk("rel_id_pc", id_pc, 32'h108);
      chk("rel_pending_addr", rom_addr, 32'h200);
      tick();
      chk("rel_target_id_pc", id_pc, 32'h200);
      // flush beats stall and branch
      flush = 1'b1;
      flush_pc = 32'h0000_0380;
      stall = 1'b1;
      branch_flag = 1'b1;
      branch_addr = 32'h0000_0500;
      tick();
      flush = 1'b0;
      stall = 1'b0;
      branch_flag = 1'b0;
      chk("flush_addr", rom_addr, 32'h380);
      chk("flush_valid", {31'd0, id_valid}, 32'd0);
      tick();
      chk("flush_id_pc", id_pc, 32'h380);
      chk("flush_no_pending", rom_addr, 32'h384);
      // plain stall
      stall = 1'b1;
      #1;
      chk("stall_rom_en", {31'd0, rom_en}, 32'd0);
      tick();
      stall = 1'b0;
      chk("stall_addr", rom_addr, 32'h384);
      chk("stall_id_pc", id_pc, 32'h380);
      tick();
      chk("post_stall_id_pc", id_pc, 32'h384);
      // misaligned branch target
      branch_flag = 1'b1;
      branch_addr = 32'h0000_0102;
      tick();
      branch_flag = 1'b0;
      chk("mis_addr", rom_addr, 32'h102);
      chk("mis_rom_en", {31'd0, rom_en}, 32'd0);
      tick();
      chk("mis_valid", {31'd0, id_valid}, 32'd1);
      chk("mis_id_pc", id_pc, 32'h102);
      chk("mis_adel", {31'd0, id_adel}, 32'd1);
      chk("mis_inst", id_inst, 32'd0);
      chk("fault_rom_en", {31'd0, rom_en}, 32'd0);
      tick();
      chk("fault_drain", {31'd0, id_valid}, 32'd0);
      chk("fault_rom_en2", {31'd0, rom_en}, 32'd0);
      tick();
      chk("fault_rom_en3", {31'd0, rom_en}, 32'd0);
      flush = 1'b1;
      flush_pc = 32'h0000_0380;
      tick();
      flush = 1'b0;
      chk("resume_addr", rom_addr, 32'h380);
      chk("resume_rom_en", {31'd0, rom_en}, 32'd1);
      tick();
      chk("resume_id_pc", id_pc, 32'h380);
      chk("resume_adel", {31'd0, id_adel}, 32'd0);
      chk("resume_inst", id_inst, 32'h380 ^ K);
      // wrap
      branch_flag = 1'b1;
      branch_addr = 32'hFFFF_FFFC;
      tick();
      branch_flag = 1'b0;
      chk("wrap_top_addr", rom_addr, 32'hFFFF_FFFC);
      tick();
      chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
      chk("wrap_addr", rom_addr, 32'h0);
      tick();
      chk("wrap_id_pc0", id_pc, 32'h0);
      // reset mid-stream
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", {31'd0, id_valid}, 32'd0);
      chk("mid_rst_addr", rom_addr, RP);
      chk("mid_rst_id_pc", id_pc, 32'd0);
      chk("mid_rst_rom_en", {31'd0, rom_en}, 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
